iir_dec_out: RTL
================

# iir_dec_out

Downstream of the IIR low-pass filter stage. Consumes the filter's wide signed output stream and performs the following steps:
- N-sample accumulate-and-dump (boxcar) decimation.
- Scaling by arithmetic shift.
- Rounding (optional).
- Saturation to the output width.
- Buffering of results in a small FIFO behind a valid/ready handshake toward the readout/host interface.

## Interface

Parameters:
- IN_WIDTH, 30: width of filter output samples (signed)
- OUT_WIDTH, 16: width of decimated output words (signed)
- DEC_LOG2, 4: log2 of decimation factor N (N = 16)
- SHIFT, 18: right-shift applied to the accumulated sum; must satisfy 1 ≤ SHIFT ≤ IN_WIDTH+DEC_LOG2
- FIFO_DEPTH, 4: output FIFO entries (power of two, ≥ 2)

Ports:
- clk  in  1  sole clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- din  in  IN_WIDTH  signed filter output sample
- din_valid  in  1  din qualifies this cycle
- clr  in  1  synchronous clear of accumulator, sample count, in-flight dump and ovf
- dout  out  OUT_WIDTH  signed decimated word (FIFO head)
- dout_valid  out  1  dout holds a valid word
- dout_ready  in  1  consumer accepts dout when dout_valid is high
- sat  out  1  one-cycle pulse: the word written this cycle was saturated
- ovf  out  1  sticky: a word was dropped because the FIFO was full

## Operation

- Accumulator width: IN_WIDTH+DEC_LOG2 bits, signed; it cannot overflow.
- Sample count `cnt`: 0..N-1, advances only on din_valid.

State machine (`st`):
- **ACC**: each din_valid adds din to acc and increments cnt.
  - When din_valid arrives with cnt = N-1, acc+din is loaded into dump_reg and the block enters DUMP.
  - On that same edge, acc ← 0 and cnt ← 0.
- **DUMP** (exactly one cycle), performing these steps on dump_reg:
  - With rounding: add 2^(SHIFT-1).
  - Arithmetic shift right by SHIFT.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Push the result to the FIFO, pulse sat if clamped, then return to ACC.
- din_valid is accepted during DUMP, because accumulation of the next block proceeds in parallel. The DUMP path must not stall input.

FIFO:
- First-word fall-through: dout equals the head entry whenever dout_valid = 1.
- Pop: dout_valid & dout_ready.
- Push while full with no simultaneous pop: the word is dropped and ovf ← 1. sat still reflects the dropped word.
- Push and pop in the same cycle while full: both succeed and no drop occurs.

clr behaviour:
- Zeroes acc and cnt, cancels a pending DUMP (no push), and clears ovf.
- Does not flush the FIFO.
- clr has priority over a simultaneous din_valid; that sample is discarded.

Reset (n_rst low, asynchronous):
- acc = 0, cnt = 0, st = ACC, FIFO empty.
- Output reset values: dout = 0, dout_valid = 0, sat = 0, ovf = 0.
- Reset asserted mid-block discards partial sums and FIFO contents.

## Timing

- The Nth valid sample is presented in cycle T:
  - dump_reg is captured at the edge ending T.
  - The FIFO write happens at the edge ending T+1.
  - With the FIFO empty, dout_valid = 1 in cycle T+2.
  - Latency: 2 cycles.
- sat is high in cycle T+2 (registered with the push).
- ovf rises in cycle T+2 of the dropped word.
- dout_ready is sampled combinationally. A pop at the edge ending cycle k shows the next entry (or dout_valid = 0) in cycle k+1.
- Throughput: one output word per N valid input samples. The input is never backpressured.

## Configuration

- DEC_ROUND_EN defined: round half-up, i.e. add 2^(SHIFT-1) before the shift.
- DEC_ROUND_EN undefined: truncate (floor by arithmetic shift). No rounding adder is instantiated.

## Structure

- Package iir_dec_pkg holds:
  - the state enum (ACC, DUMP);
  - the saturation function sat_to_width;
  - localparams N and ACC_WIDTH.
- Sub-module iir_dec_fifo provides the FIFO:
  - parameterised depth and width;
  - first-word fall-through;
  - full/empty flags;
  - the simultaneous push/pop-when-full rule.
- The top level contains the accumulator, counter, FSM, scale/round/saturate and the flags.

## Test plan

All cases use defaults (N = 16, SHIFT = 18) unless stated.

- **Basic decimation:** din = 16384 × 16 consecutive valid samples → a single word of 1, dout_valid high 2 cycles after the 16th sample, sat = 0.
- **Rounding:** din = 8192 × 16 (sum 2^17) → 0 without DEC_ROUND_EN, 1 with it.
- **Saturation:**
  - din = 536870911 × 16 → 32767 in both builds; the DEC_ROUND_EN build pulses sat.
  - din = −536870912 × 16 → −32768, sat = 0.
- **Gapped input:** din = 16384 with din_valid toggling every other cycle for 32 cycles → exactly one word = 1. Invalid cycles are ignored.
- **Backpressure/overflow:** dout_ready = 0 over 5 blocks with din = 16384·k for block k = 1..5 → FIFO holds 1, 2, 3, 4, the 5th is dropped and ovf = 1. After raising dout_ready, the words drain in order 1, 2, 3, 4; clr then clears ovf.
- **clr and reset mid-block:** after 10 samples of 16384, assert clr → the next 16 samples yield exactly 1. Asserting n_rst mid-block empties the FIFO and zeroes all outputs immediately.

Source files
------------

// File: rtl/iir_dec_pkg.sv
// iir_dec_pkg: shared FSM state type, default decimator configuration and saturation helper.
//   N          default decimation factor
//   ACC_WIDTH  default accumulator width (IN_WIDTH + log2(N))
//   st_t       decimator state (ACC accumulating, DUMP scaling/pushing a finished block)
//   sat_to_width clamps a wide signed value to a signed w-bit range and flags clipping
package iir_dec_pkg;

    localparam int N         = 16;
    localparam int ACC_WIDTH = 34;

    typedef enum logic {
        ACC,
        DUMP
    } st_t;

    typedef struct packed {
        logic               clip;
        logic signed [63:0] val;
    } sat_res_t;

    function automatic sat_res_t sat_to_width(input logic signed [63:0] x, input int w);
        sat_res_t           r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi     = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo     = -(64'sd1 <<< (w - 1));
        r.clip = (x > hi) || (x < lo);
        r.val  = (x > hi) ? hi : ((x < lo) ? lo : x);
        return r;
    endfunction

endpackage

// File: rtl/iir_dec_fifo.sv
// iir_dec_fifo: first-word fall-through FIFO for decimated words.
//   clk, n_rst  clock, asynchronous active-low reset (empties the FIFO)
//   wr_en       push request; accepted when not full, or when full with a pop this cycle
//   wr_data     word to push
//   rd_en       pop request; ignored while empty
//   rd_data     head entry (0 while empty)
//   full, empty occupancy flags
module iir_dec_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wp;
    logic [PW:0]      rp;
    logic             wr;
    logic             rd;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty   = wp == rp;
    assign full    = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
    assign rd      = rd_en && !empty;
    // When full, a simultaneous pop frees the head slot the write lands in.
    assign wr      = wr_en && (!full || rd);
    assign rd_data = empty ? '0 : mem[rp[PW-1:0]];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr) wp <= wp + (PW + 1)'(1);
            if (rd) rp <= rp + (PW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wp[PW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/iir_dec_out.sv
// iir_dec_out: boxcar decimator for the IIR filter output; accumulates N samples, shifts,
// optionally rounds, saturates and queues results behind a valid/ready FIFO.
// Build option: define DEC_ROUND_EN for round-half-up before the shift (default truncates).
//   clk, n_rst  clock, asynchronous active-low reset
//   din         signed filter sample, qualified by din_valid (never backpressured)
//   clr         synchronous clear of accumulator, count, pending dump and ovf
//   dout        signed decimated word at FIFO head, qualified by dout_valid
//   dout_ready  consumer pops dout when dout_valid is high
//   sat         one-cycle pulse when the word just written (or dropped) was clamped
//   ovf         sticky: a word was dropped because the FIFO was full
module iir_dec_out import iir_dec_pkg::*; #(
    parameter int IN_WIDTH   = ACC_WIDTH - $clog2(N),
    parameter int OUT_WIDTH  = 16,
    parameter int DEC_LOG2   = $clog2(N),
    parameter int SHIFT      = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic signed [IN_WIDTH-1:0]  din,
    input  logic                        din_valid,
    input  logic                        clr,
    output logic signed [OUT_WIDTH-1:0] dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic                        sat,
    output logic                        ovf
);

    localparam int AW = IN_WIDTH + DEC_LOG2;

    st_t                 st;
    st_t                 st_nx;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] dump_reg;
    logic [DEC_LOG2-1:0]  cnt;
    logic                 last;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic signed [63:0]   ext;
    logic signed [63:0]   scaled;
    sat_res_t             sr;
    logic                 unused_hi;

    assign sum  = acc + AW'(din);
    assign last = din_valid && (cnt == '1);

    always_comb begin
        st_nx = ACC;
        if (!clr && last) st_nx = DUMP;
    end

    // A clear arriving during DUMP cancels that block's push.
    assign push = (st == DUMP) && !clr;
    assign pop  = dout_valid && dout_ready;

    always_comb begin
`ifdef DEC_ROUND_EN
        ext = 64'(dump_reg) + (64'sd1 <<< (SHIFT - 1));
`else
        ext = 64'(dump_reg);
`endif
        scaled = ext >>> SHIFT;
        sr     = sat_to_width(scaled, OUT_WIDTH);
    end

    assign unused_hi = ^sr.val[63:OUT_WIDTH];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            st       <= ACC;
            acc      <= '0;
            cnt      <= '0;
            dump_reg <= '0;
            sat      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            st  <= st_nx;
            sat <= push && sr.clip;
            if (clr) ovf <= 1'b0;
            else if (push && full && !pop) ovf <= 1'b1;
            // The next block starts accumulating in the same cycle the previous one dumps.
            if (clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (din_valid) begin
                cnt <= cnt + DEC_LOG2'(1);
                if (last) begin
                    dump_reg <= sum;
                    acc      <= '0;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

    iir_dec_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(OUT_WIDTH)
    ) u_fifo (
        .clk    (clk),
        .n_rst  (n_rst),
        .wr_en  (push),
        .wr_data(sr.val[OUT_WIDTH-1:0]),
        .rd_en  (dout_ready),
        .rd_data(dout),
        .full   (full),
        .empty  (empty)
    );

    assign dout_valid = !empty;

endmodule
